// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its sequencing controller.
// master = datapath side, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic        ext_stall;
  logic [5:0]  op_d;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic [5:0]  op_e;
  logic [4:0]  rd_e;
  logic        pc_we;
  logic        pc_sel;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        halted;
  logic [15:0] stall_cycles;

  modport master (
    output ext_stall, op_d, rs_d, rt_d, op_e, rd_e,
    input  pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, halted, stall_cycles
  );

  modport slave (
    input  ext_stall, op_d, rs_d, rt_d, op_e, rd_e,
    output pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, halted, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch/jr resolution waits,
// jump redirects, external freezes, terminal halt and a saturating stall counter.
//
// state   | meaning
// RUN     | normal issue; decode evaluated for halt/hazard/branch/jump
// LDSTALL | extra load-use bubbles, cnt counts the remaining ones
// BRWAIT  | waiting for the branch/jr target, cnt counts down to redirect
// HALT    | terminal; left only through reset
module pipe_ctrl #(
  parameter int unsigned LOAD_STALL = 2,
  parameter int unsigned BR_SLOTS   = 2
) (
  input  logic       clk,
  input  logic       rstd,
  pipe_ctrl_if.slave bus
);

  localparam logic [5:0] OP_LOAD = 6'd16;
  localparam logic [5:0] OP_JUMP = 6'd40;
  localparam logic [5:0] OP_JR   = 6'd42;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] LD_CNT_INIT = 2'(LOAD_STALL - 1);
  localparam logic [1:0] BR_CNT_INIT = 2'(BR_SLOTS);

  typedef enum logic [1:0] {RUN, LDSTALL, BRWAIT, HALT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic [15:0] r_stall_cycles;

  logic w_is_branch;
  logic w_is_jr;
  logic w_is_jump;
  logic w_is_halt;
  logic w_uses_rt;
  logic w_hazard;

  logic w_pc_we;
  logic w_pc_sel;
  logic w_ifid_we;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_halted;

  assign w_is_branch = (bus.op_d >= 6'd32) && (bus.op_d <= 6'd35);
  assign w_is_jr     = (bus.op_d == OP_JR);
  assign w_is_jump   = (bus.op_d == OP_JUMP);
  assign w_is_halt   = (bus.op_d == OP_HALT);
  // jr reads only rs; jump and halt read no registers at all
  assign w_uses_rt   = !(w_is_jr || w_is_jump || w_is_halt);
  assign w_hazard    = (bus.op_e == OP_LOAD) && (bus.rd_e != 5'd0) &&
                       ((bus.rd_e == bus.rs_d) || (w_uses_rt && (bus.rd_e == bus.rt_d)));

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pc_we      = 1'b1;
    w_pc_sel     = 1'b0;
    w_ifid_we    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_halted     = 1'b0;
    // outputs sit at their idle values for as long as reset is held
    if (rstd) begin
      if ((r_state != HALT) && bus.ext_stall) begin
        w_pc_we   = 1'b0;
        w_ifid_we = 1'b0;
      end else begin
        case (r_state)
          RUN: begin
            if (w_is_halt) begin
              w_pc_we     = 1'b0;
              w_ifid_we   = 1'b0;
              w_state_nxt = HALT;
            end else if (w_hazard) begin
              w_pc_we      = 1'b0;
              w_ifid_we    = 1'b0;
              w_idex_flush = 1'b1;
              if (LOAD_STALL > 1) begin
                w_state_nxt = LDSTALL;
                w_cnt_nxt   = LD_CNT_INIT;
              end
            end else if (w_is_branch || w_is_jr) begin
              w_pc_we      = 1'b0;
              w_ifid_flush = 1'b1;
              w_state_nxt  = BRWAIT;
              w_cnt_nxt    = BR_CNT_INIT;
            end else if (w_is_jump) begin
              w_ifid_flush = 1'b1;
            end
          end
          LDSTALL: begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_flush = 1'b1;
            if (r_cnt <= 2'd1) begin
              w_state_nxt = RUN;
              w_cnt_nxt   = 2'd0;
            end else begin
              w_cnt_nxt = r_cnt - 2'd1;
            end
          end
          BRWAIT: begin
            w_ifid_flush = 1'b1;
            if (r_cnt > 2'd1) begin
              w_pc_we   = 1'b0;
              w_cnt_nxt = r_cnt - 2'd1;
            end else begin
              w_pc_sel    = 1'b1;
              w_state_nxt = RUN;
              w_cnt_nxt   = 2'd0;
            end
          end
          HALT: begin
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_halted  = 1'b1;
          end
          default: begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_stall_cycles <= 16'd0;
    end else if (!w_pc_we && (r_state != HALT) && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign bus.pc_we        = w_pc_we;
  assign bus.pc_sel       = w_pc_sel;
  assign bus.ifid_we      = w_ifid_we;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_flush   = w_idex_flush;
  assign bus.halted       = w_halted;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (LOAD_STALL=2 and LOAD_STALL=1, BR_SLOTS=2),
// cycle tables with hand-derived expectations checked through an expected-value queue.
module tb_pipe_ctrl;

  // ctl packing: {pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, halted}
  typedef struct {
    logic        ext;
    logic [5:0]  opd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  ope;
    logic [4:0]  rde;
    logic [5:0]  ctl;
    logic [15:0] stl;
  } vec_t;

  typedef struct {
    logic [5:0]  ctl;
    logic [15:0] stl;
    int          dut;
  } exp_t;

  localparam logic [5:0] C_IDLE = 6'b101000;

  logic clk = 1'b0;
  logic rstd;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t tab_a[$];
  vec_t tab_b[$];

  always #5 clk = ~clk;

  pipe_ctrl_if if0 ();
  pipe_ctrl_if if1 ();

  pipe_ctrl #(.LOAD_STALL(2), .BR_SLOTS(2)) dut0 (.clk(clk), .rstd(rstd), .bus(if0));
  pipe_ctrl #(.LOAD_STALL(1), .BR_SLOTS(2)) dut1 (.clk(clk), .rstd(rstd), .bus(if1));

  function automatic vec_t mk(logic ext, logic [5:0] opd, logic [4:0] rs, logic [4:0] rt,
                              logic [5:0] ope, logic [4:0] rde, logic [5:0] ctl, logic [15:0] stl);
    vec_t v;
    v.ext = ext; v.opd = opd; v.rs = rs; v.rt = rt; v.ope = ope; v.rde = rde;
    v.ctl = ctl; v.stl = stl;
    return v;
  endfunction

  function automatic vec_t nop(logic [5:0] ctl, logic [15:0] stl);
    return mk(1'b0, 6'd0, 5'd1, 5'd2, 6'd0, 5'd0, ctl, stl);
  endfunction

  task automatic drive(logic ext, logic [5:0] opd, logic [4:0] rs, logic [4:0] rt,
                       logic [5:0] ope, logic [4:0] rde);
    if0.ext_stall = ext; if0.op_d = opd; if0.rs_d = rs; if0.rt_d = rt; if0.op_e = ope; if0.rd_e = rde;
    if1.ext_stall = ext; if1.op_d = opd; if1.rs_d = rs; if1.rt_d = rt; if1.op_e = ope; if1.rd_e = rde;
  endtask

  task automatic expect_out(logic [5:0] ctl, logic [15:0] stl, int dut);
    exp_t e;
    e.ctl = ctl; e.stl = stl; e.dut = dut;
    sb.push_back(e);
  endtask

  task automatic compare(string tag, int idx);
    exp_t        e;
    logic [5:0]  a_ctl;
    logic [15:0] a_stl;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s[%0d]: no expected entry queued", tag, idx);
    end else begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        a_ctl = {if0.pc_we, if0.pc_sel, if0.ifid_we, if0.ifid_flush, if0.idex_flush, if0.halted};
        a_stl = if0.stall_cycles;
      end else begin
        a_ctl = {if1.pc_we, if1.pc_sel, if1.ifid_we, if1.ifid_flush, if1.idex_flush, if1.halted};
        a_stl = if1.stall_cycles;
      end
      if ((a_ctl !== e.ctl) || (a_stl !== e.stl)) begin
        bad++;
        $display("FAIL %s[%0d] dut%0d: ctl got %b want %b, stall_cycles got %0d want %0d",
                 tag, idx, e.dut, a_ctl, e.ctl, a_stl, e.stl);
      end
    end
  endtask

  // called at posedge+1; checks at the following negedge, returns at posedge+1
  task automatic run_vec(vec_t v, int dut, string tag, int idx);
    drive(v.ext, v.opd, v.rs, v.rt, v.ope, v.rde);
    expect_out(v.ctl, v.stl, dut);
    @(negedge clk);
    compare(tag, idx);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(string tag);
    rstd = 1'b0;
    drive(1'b1, 6'd63, 5'd5, 5'd5, 6'd16, 5'd5);
    expect_out(C_IDLE, 16'd0, 0);
    expect_out(C_IDLE, 16'd0, 1);
    #2;
    compare(tag, 0);
    compare(tag, 1);
    @(posedge clk);
    #1;
    rstd = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // cycle table for dut0 (LOAD_STALL=2, BR_SLOTS=2), starting right after reset
    tab_a.push_back(nop(C_IDLE, 16'd0));
    tab_a.push_back(nop(C_IDLE, 16'd0));
    tab_a.push_back(nop(C_IDLE, 16'd0));
    tab_a.push_back(mk(0, 6'd0,  5'd1, 5'd5, 6'd16, 5'd5, 6'b000010, 16'd0));  // load-use on rt
    tab_a.push_back(nop(6'b000010, 16'd1));
    tab_a.push_back(nop(C_IDLE, 16'd2));
    tab_a.push_back(mk(0, 6'd0,  5'd0, 5'd0, 6'd16, 5'd0, C_IDLE, 16'd2));     // rd_e==0: no hazard
    tab_a.push_back(mk(0, 6'd42, 5'd7, 5'd2, 6'd16, 5'd7, 6'b000010, 16'd2));  // jr behind load on rs
    tab_a.push_back(mk(0, 6'd42, 5'd7, 5'd2, 6'd0,  5'd0, 6'b000010, 16'd3));
    tab_a.push_back(mk(0, 6'd42, 5'd7, 5'd2, 6'd0,  5'd0, 6'b001100, 16'd4));  // jr re-evaluated in RUN
    tab_a.push_back(nop(6'b001100, 16'd5));
    tab_a.push_back(nop(6'b111100, 16'd6));
    tab_a.push_back(nop(C_IDLE, 16'd6));
    tab_a.push_back(mk(0, 6'd42, 5'd1, 5'd9, 6'd16, 5'd9, 6'b001100, 16'd6));  // jr ignores rt match
    tab_a.push_back(nop(6'b001100, 16'd7));
    tab_a.push_back(nop(6'b111100, 16'd8));
    tab_a.push_back(nop(C_IDLE, 16'd8));
    tab_a.push_back(mk(0, 6'd40, 5'd1, 5'd2, 6'd0,  5'd0, 6'b101100, 16'd8));  // jump
    tab_a.push_back(nop(C_IDLE, 16'd8));
    tab_a.push_back(mk(0, 6'd40, 5'd1, 5'd4, 6'd16, 5'd4, 6'b101100, 16'd8));  // jump ignores rt match
    tab_a.push_back(mk(0, 6'd32, 5'd1, 5'd2, 6'd0,  5'd0, 6'b001100, 16'd8));  // branch
    tab_a.push_back(mk(1, 6'd0,  5'd1, 5'd2, 6'd0,  5'd0, 6'b000000, 16'd9));  // freeze in BRWAIT
    tab_a.push_back(mk(1, 6'd0,  5'd1, 5'd2, 6'd0,  5'd0, 6'b000000, 16'd10));
    tab_a.push_back(mk(1, 6'd0,  5'd1, 5'd2, 6'd0,  5'd0, 6'b000000, 16'd11));
    tab_a.push_back(mk(1, 6'd0,  5'd1, 5'd2, 6'd0,  5'd0, 6'b000000, 16'd12));
    tab_a.push_back(nop(6'b001100, 16'd13));
    tab_a.push_back(nop(6'b111100, 16'd14));
    tab_a.push_back(nop(C_IDLE, 16'd14));
    tab_a.push_back(mk(1, 6'd0,  5'd1, 5'd5, 6'd16, 5'd5, 6'b000000, 16'd14)); // freeze beats hazard
    tab_a.push_back(nop(C_IDLE, 16'd15));
    tab_a.push_back(mk(0, 6'd0,  5'd1, 5'd5, 6'd16, 5'd5, 6'b000010, 16'd15));
    tab_a.push_back(mk(1, 6'd0,  5'd1, 5'd2, 6'd0,  5'd0, 6'b000000, 16'd16)); // freeze in LDSTALL
    tab_a.push_back(nop(6'b000010, 16'd17));
    tab_a.push_back(nop(C_IDLE, 16'd18));
    tab_a.push_back(mk(0, 6'd63, 5'd5, 5'd2, 6'd16, 5'd5, 6'b000000, 16'd18)); // halt beats hazard
    tab_a.push_back(nop(6'b000001, 16'd19));
    tab_a.push_back(mk(1, 6'd0,  5'd1, 5'd2, 6'd0,  5'd0, 6'b000001, 16'd19));
    tab_a.push_back(nop(6'b000001, 16'd19));
    tab_a.push_back(mk(1, 6'd0,  5'd1, 5'd2, 6'd0,  5'd0, 6'b000001, 16'd19));
    tab_a.push_back(mk(0, 6'd0,  5'd1, 5'd5, 6'd16, 5'd5, 6'b000001, 16'd19));

    // cycle table for dut1 (LOAD_STALL=1): branch behind a load, single-cycle bubble
    tab_b.push_back(mk(0, 6'd33, 5'd3, 5'd1, 6'd16, 5'd3, 6'b000010, 16'd0));
    tab_b.push_back(mk(0, 6'd33, 5'd3, 5'd1, 6'd0,  5'd0, 6'b001100, 16'd1));
    tab_b.push_back(nop(6'b001100, 16'd2));
    tab_b.push_back(nop(6'b111100, 16'd3));
    tab_b.push_back(nop(C_IDLE, 16'd3));
    tab_b.push_back(mk(0, 6'd5,  5'd1, 5'd6, 6'd16, 5'd6, 6'b000010, 16'd3));
    tab_b.push_back(nop(C_IDLE, 16'd4));

    rstd = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
            (i % 2 == 0) ? 6'd16 : 6'($urandom), 5'($urandom));
      expect_out(C_IDLE, 16'd0, i % 2);
      @(negedge clk);
      compare("reset_hold", i);
      @(posedge clk);
      #1;
    end
    rstd = 1'b1;

    for (int i = 0; i < tab_a.size(); i++) run_vec(tab_a[i], 0, "tab_a", i);

    reset_pulse("rst_from_halt");
    run_vec(nop(C_IDLE, 16'd0), 0, "after_halt_rst", 0);

    run_vec(mk(0, 6'd32, 5'd1, 5'd2, 6'd0, 5'd0, 6'b001100, 16'd0), 0, "brwait_rst", 0);
    run_vec(nop(6'b001100, 16'd1), 0, "brwait_rst", 1);
    reset_pulse("rst_in_brwait");
    run_vec(nop(C_IDLE, 16'd0), 0, "after_brwait_rst", 0);

    run_vec(mk(0, 6'd0, 5'd5, 5'd2, 6'd16, 5'd5, 6'b000010, 16'd0), 0, "ldstall_rst", 0);
    reset_pulse("rst_in_ldstall");
    run_vec(nop(C_IDLE, 16'd0), 0, "after_ldstall_rst", 0);

    for (int i = 0; i < tab_b.size(); i++) run_vec(tab_b[i], 1, "tab_b", i);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
